// File: rtl/modn_updown_counter.sv
// Modulo-MOD up/down counter with clear, clamped parallel load and cascade terminal count.
// Q/Wrap/LdErr register one edge after their inputs; Tc is combinational; no backpressure.
module modn_updown_counter #(
    parameter int W   = 3,
    parameter int MOD = 7
) (
    input  logic         Cp,
    input  logic         _R,
    input  logic         En,
    input  logic         Up,
    input  logic         Clr,
    input  logic         Ld,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         Tc,
    output logic         Wrap,
    output logic         LdErr
);

    if (MOD < 2 || MOD > (1 << W)) begin : g_bad_mod
        $fatal(1, "modn_updown_counter: MOD=%0d outside 2..2**W (W=%0d)", MOD, W);
    end

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic [W-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic         lderr_q, lderr_d;

    // Priority Clr > Ld > En; the pulse outputs default low every edge.
    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        lderr_d = 1'b0;
        if (Clr) begin
            q_d = '0;
        end else if (Ld) begin
            if (D > TOP) begin
                q_d     = TOP;
                lderr_d = 1'b1;
            end else begin
                q_d = D;
            end
        end else if (En) begin
            if (Up) begin
                if (q_q == TOP) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = TOP;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Cp) begin
        if (!_R) begin
            q_q     <= '0;
            wrap_q  <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            lderr_q <= lderr_d;
        end
    end

    // Combinational so a downstream stage advances on the same edge this one wraps.
    assign Tc    = En & ((Up & (q_q == TOP)) | (~Up & (q_q == '0)));
    assign Q     = q_q;
    assign Wrap  = wrap_q;
    assign LdErr = lderr_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: directed vector table, cascade sequence, randomized model check.
module tb_modn_updown_counter;

    logic       cp = 1'b0;
    logic       r_n, en, up, clr, ld;
    logic [2:0] d;
    logic [2:0] q, q8;
    logic       tc, wrap, lderr, tc8, wrap8, lderr8;

    logic       cr_n, c_en0;
    logic [2:0] cq0, cq1;
    logic       ctc0, ctc1, cwrap0, cwrap1, clderr0, clderr1;
    logic       c_up, c_clr, c_ld;
    logic [2:0] c_d;

    int n_pass  = 0;
    int n_total = 0;

    always #5 cp = ~cp;

    modn_updown_counter #(.W(3), .MOD(7)) dut (
        .Cp(cp), ._R(r_n), .En(en), .Up(up), .Clr(clr), .Ld(ld), .D(d),
        .Q(q), .Tc(tc), .Wrap(wrap), .LdErr(lderr)
    );

    modn_updown_counter #(.W(3), .MOD(8)) dut8 (
        .Cp(cp), ._R(r_n), .En(en), .Up(up), .Clr(clr), .Ld(ld), .D(d),
        .Q(q8), .Tc(tc8), .Wrap(wrap8), .LdErr(lderr8)
    );

    modn_updown_counter #(.W(3), .MOD(7)) c0 (
        .Cp(cp), ._R(cr_n), .En(c_en0), .Up(c_up), .Clr(c_clr), .Ld(c_ld), .D(c_d),
        .Q(cq0), .Tc(ctc0), .Wrap(cwrap0), .LdErr(clderr0)
    );

    modn_updown_counter #(.W(3), .MOD(7)) c1 (
        .Cp(cp), ._R(cr_n), .En(ctc0), .Up(c_up), .Clr(c_clr), .Ld(c_ld), .D(c_d),
        .Q(cq1), .Tc(ctc1), .Wrap(cwrap1), .LdErr(clderr1)
    );

    typedef struct {
        bit r_n, en, up, clr, ld;
        int d;
        int q, wrap, lderr, tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit e, bit u, bit c, bit l, int dv,
                                int eq, int ew, int el, int et);
        vec_t v;
        v.r_n = r; v.en = e; v.up = u; v.clr = c; v.ld = l; v.d = dv;
        v.q = eq; v.wrap = ew; v.lderr = el; v.tc = et;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference: counting is plain modular arithmetic on integers.
    task automatic model_step(input int mod, input bit r, input bit c, input bit l,
                              input bit e, input bit u, input int dv,
                              inout int mq, output int mw, output int ml);
        mw = 0;
        ml = 0;
        if (!r || c) mq = 0;
        else if (l) begin
            if (dv >= mod) begin mq = mod - 1; ml = 1; end
            else mq = dv;
        end else if (e) begin
            if (u) begin mw = (mq == mod - 1) ? 1 : 0; mq = (mq + 1) % mod; end
            else   begin mw = (mq == 0) ? 1 : 0;       mq = (mq + mod - 1) % mod; end
        end
    endtask

    function automatic int model_tc(int mod, bit e, bit u, int mq);
        return (e && ((u && mq == mod - 1) || (!u && mq == 0))) ? 1 : 0;
    endfunction

    initial begin
        int m7, m8, w7, w8, l7, l8;

        r_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; ld = 1'b0; d = '0;
        cr_n = 1'b0; c_en0 = 1'b0; c_up = 1'b1; c_clr = 1'b0; c_ld = 1'b0; c_d = '0;

        // Count up through the wrap
        vecs.push_back(mk(0,0,1,0,0,0, 0,0,0,0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1,1,1,0,0,0, i % 7, (i == 7) ? 1 : 0, 0, (i == 6) ? 1 : 0));
        // Count down from reset
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0, 6,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0, 5,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0, 4,0,0,0));
        // Loads: in range, clamp, pulse drops
        vecs.push_back(mk(1,0,1,0,1,5, 5,0,0,0));
        vecs.push_back(mk(1,0,1,0,1,7, 6,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,0, 6,0,0,0));
        // Reset beats everything else, counting resumes at 1
        vecs.push_back(mk(0,0,1,0,0,0, 0,0,0,0));
        for (int i = 1; i <= 4; i++)
            vecs.push_back(mk(1,1,1,0,0,0, i,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,5, 0,0,0,0));
        vecs.push_back(mk(1,1,1,0,0,0, 1,0,0,0));
        // Clr over Ld, Ld over En, hold
        vecs.push_back(mk(1,0,1,1,1,3, 0,0,0,0));
        vecs.push_back(mk(1,1,1,0,1,2, 2,0,0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,0,1,0,0,0, 2,0,0,0));
        // Clr at MOD-1 with En/Up is not a wrap
        vecs.push_back(mk(1,0,1,0,1,6, 6,0,0,0));
        vecs.push_back(mk(1,1,1,1,0,0, 0,0,0,0));
        // Direction flip takes effect on the next enabled edge
        vecs.push_back(mk(1,1,1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0, 0,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0, 6,1,0,0));
        vecs.push_back(mk(1,1,1,0,0,0, 0,1,0,0));

        @(posedge cp); #1;
        foreach (vecs[i]) begin
            r_n = vecs[i].r_n; en = vecs[i].en; up = vecs[i].up;
            clr = vecs[i].clr; ld = vecs[i].ld; d = 3'(vecs[i].d);
            @(posedge cp); #1;
            check($sformatf("vec%0d_q", i),     int'(q),     vecs[i].q);
            check($sformatf("vec%0d_wrap", i),  int'(wrap),  vecs[i].wrap);
            check($sformatf("vec%0d_lderr", i), int'(lderr), vecs[i].lderr);
            check($sformatf("vec%0d_tc", i),    int'(tc),    vecs[i].tc);
        end

        // Two-digit cascade: 49 edges brings {Q1,Q0} back to {0,0}
        cr_n = 1'b0; c_en0 = 1'b1;
        @(posedge cp); #1;
        check("casc_rst_q0", int'(cq0), 0);
        check("casc_rst_q1", int'(cq1), 0);
        cr_n = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            @(posedge cp); #1;
            check($sformatf("casc%0d_q0", k),    int'(cq0),    k % 7);
            check($sformatf("casc%0d_q1", k),    int'(cq1),    (k / 7) % 7);
            check($sformatf("casc%0d_wrap0", k), int'(cwrap0), (k % 7 == 0) ? 1 : 0);
            check($sformatf("casc%0d_wrap1", k), int'(cwrap1), (k == 49) ? 1 : 0);
            check($sformatf("casc%0d_tc0", k),   int'(ctc0),   (k % 7 == 6) ? 1 : 0);
        end

        // Randomized run on MOD=7 and MOD=8 (full-range) instances
        r_n = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0;
        @(posedge cp); #1;
        m7 = 0; m8 = 0;
        for (int n = 0; n < 400; n++) begin
            r_n = ($urandom_range(31) != 0);
            clr = ($urandom_range(15) == 0);
            ld  = ($urandom_range(7) == 0);
            en  = ($urandom_range(3) != 0);
            up  = 1'($urandom_range(1));
            d   = 3'($urandom_range(7));
            #1;
            check("rnd7_tc", int'(tc),  model_tc(7, en, up, m7));
            check("rnd8_tc", int'(tc8), model_tc(8, en, up, m8));
            model_step(7, r_n, clr, ld, en, up, int'(d), m7, w7, l7);
            model_step(8, r_n, clr, ld, en, up, int'(d), m8, w8, l8);
            @(posedge cp); #1;
            check("rnd7_q",     int'(q),      m7);
            check("rnd7_wrap",  int'(wrap),   w7);
            check("rnd7_lderr", int'(lderr),  l7);
            check("rnd8_q",     int'(q8),     m8);
            check("rnd8_wrap",  int'(wrap8),  w8);
            check("rnd8_lderr", int'(lderr8), l8);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
